// File: rtl/board_access_arbiter_if.sv
// Board access bundle: CPU request port, clear control and the cell-store bus.
// The arbiter connects through the slave modport; the requester/store side uses master.
interface board_access_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [4:0] cpu_x;
    logic [4:0] cpu_y;
    logic [3:0] cpu_wdata;
    logic       cpu_ack;
    logic       cpu_err;
    logic [3:0] cpu_rdata;
    logic       clear_start;
    logic       clear_busy;
    logic       clear_done;
    logic       st_we;
    logic       st_re;
    logic [4:0] st_x;
    logic [4:0] st_y;
    logic [3:0] st_wdata;
    logic [3:0] st_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_x, cpu_y, cpu_wdata, clear_start, st_rdata,
        input  cpu_ack, cpu_err, cpu_rdata, clear_busy, clear_done,
               st_we, st_re, st_x, st_y, st_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_x, cpu_y, cpu_wdata, clear_start, st_rdata,
        output cpu_ack, cpu_err, cpu_rdata, clear_busy, clear_done,
               st_we, st_re, st_x, st_y, st_wdata
    );
endinterface

// File: rtl/board_access_arbiter.sv
// Sole master of the board cell store: serves CPU loads/stores and a row-major
// clear sweep that zeroes every cell one per cycle.
module board_access_arbiter #(
    parameter int COLS = 20,
    parameter int ROWS = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    board_access_arbiter_if.slave bus
);

    localparam logic [4:0] COLS_L = 5'(COLS);
    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [4:0] LAST_X = 5'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        ACK      = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    state_t     state_r;
    logic       pending_r;
    logic       cpu_ack_r;
    logic       cpu_err_r;
    logic [3:0] cpu_rdata_r;
    logic       clear_busy_r;
    logic       clear_done_r;
    logic       st_we_r;
    logic       st_re_r;
    logic [4:0] st_x_r;
    logic [4:0] st_y_r;
    logic [3:0] st_wdata_r;

    logic       in_range_s;
    logic       clear_req_s;
    logic       sweep_last_s;
    logic [4:0] next_x_s;
    logic [4:0] next_y_s;

    // Request decode and next sweep cell, derived from the cell currently being written.
    always_comb begin
        in_range_s   = (bus.cpu_x < COLS_L) && (bus.cpu_y < ROWS_L);
        clear_req_s  = pending_r | bus.clear_start;
        sweep_last_s = (st_x_r == LAST_X) && (st_y_r == LAST_Y);
        if (st_x_r == LAST_X) begin
            next_x_s = 5'd0;
            next_y_s = st_y_r + 5'd1;
        end else begin
            next_x_s = st_x_r + 5'd1;
            next_y_s = st_y_r;
        end
    end

    // Arbitration FSM; strobes and pulses default low so the store bus idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            pending_r    <= 1'b0;
            cpu_ack_r    <= 1'b0;
            cpu_err_r    <= 1'b0;
            cpu_rdata_r  <= 4'd0;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
            st_we_r      <= 1'b0;
            st_re_r      <= 1'b0;
            st_x_r       <= 5'd0;
            st_y_r       <= 5'd0;
            st_wdata_r   <= 4'd0;
        end else begin
            cpu_ack_r    <= 1'b0;
            cpu_err_r    <= 1'b0;
            clear_done_r <= 1'b0;
            st_we_r      <= 1'b0;
            st_re_r      <= 1'b0;
            st_x_r       <= 5'd0;
            st_y_r       <= 5'd0;
            st_wdata_r   <= 4'd0;
            if (bus.clear_start && (state_r != CLEAR)) begin
                pending_r    <= 1'b1;
                clear_busy_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    // A clear raised in this very cycle still wins over the CPU.
                    if (clear_req_s) begin
                        state_r      <= CLEAR;
                        pending_r    <= 1'b0;
                        clear_busy_r <= 1'b1;
                        st_we_r      <= 1'b1;
                    end else if (bus.cpu_req) begin
                        if (!in_range_s) begin
                            state_r     <= ACK;
                            cpu_ack_r   <= 1'b1;
                            cpu_err_r   <= 1'b1;
                            cpu_rdata_r <= 4'd0;
                        end else if (bus.cpu_we) begin
                            state_r    <= WR;
                            st_we_r    <= 1'b1;
                            st_x_r     <= bus.cpu_x;
                            st_y_r     <= bus.cpu_y;
                            st_wdata_r <= bus.cpu_wdata;
                            cpu_ack_r  <= 1'b1;
                        end else begin
                            state_r <= RD_ISSUE;
                            st_re_r <= 1'b1;
                            st_x_r  <= bus.cpu_x;
                            st_y_r  <= bus.cpu_y;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WR: begin
                    state_r <= IDLE;
                end
                RD_ISSUE: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    state_r     <= ACK;
                    cpu_rdata_r <= bus.st_rdata;
                    cpu_ack_r   <= 1'b1;
                end
                ACK: begin
                    state_r <= IDLE;
                end
                CLEAR: begin
                    if (sweep_last_s) begin
                        state_r      <= IDLE;
                        clear_done_r <= 1'b1;
                        clear_busy_r <= 1'b0;
                    end else begin
                        state_r <= CLEAR;
                        st_we_r <= 1'b1;
                        st_x_r  <= next_x_s;
                        st_y_r  <= next_y_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack    = cpu_ack_r;
    assign bus.cpu_err    = cpu_err_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.clear_busy = clear_busy_r;
    assign bus.clear_done = clear_done_r;
    assign bus.st_we      = st_we_r;
    assign bus.st_re      = st_re_r;
    assign bus.st_x       = st_x_r;
    assign bus.st_y       = st_y_r;
    assign bus.st_wdata   = st_wdata_r;

endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter: a table of single CPU transactions
// followed by hand-written clear-sweep, back-to-back and reset sequences.
module tb_board_access_arbiter;

    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic clk;
    logic rst;
    board_access_arbiter_if bus ();

    board_access_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [4:0] x;
        logic [4:0] y;
        logic [3:0] wdata;
        logic [3:0] rdata;
        logic       exp_err;
        logic [3:0] exp_rdata;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    int sw_writes;
    int sw_bad;
    bit sw_done;
    bit sw_done_ok;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_x     = v.x;
        bus.cpu_y     = v.y;
        bus.cpu_wdata = v.wdata;
        bus.st_rdata  = ~v.rdata;
        step();
        if (v.exp_err) begin
            chk({nm, ".ack"},   32'(bus.cpu_ack),   32'd1);
            chk({nm, ".err"},   32'(bus.cpu_err),   32'd1);
            chk({nm, ".rdata"}, 32'(bus.cpu_rdata), 32'(v.exp_rdata));
            chk({nm, ".nost"},  32'({bus.st_we, bus.st_re}), 32'd0);
            bus.cpu_req = 1'b0;
            step();
            chk({nm, ".ack_end"}, 32'({bus.cpu_ack, bus.cpu_err}), 32'd0);
            chk({nm, ".nost2"},   32'({bus.st_we, bus.st_re}), 32'd0);
        end else if (v.we) begin
            chk({nm, ".we"},    32'({bus.st_we, bus.st_re}), 32'd2);
            chk({nm, ".addr"},  32'({bus.st_x, bus.st_y}), 32'({v.x, v.y}));
            chk({nm, ".wdata"}, 32'(bus.st_wdata), 32'(v.wdata));
            chk({nm, ".ack"},   32'({bus.cpu_ack, bus.cpu_err}), 32'd2);
            chk({nm, ".hold"},  32'(bus.cpu_rdata), 32'(v.exp_rdata));
            bus.cpu_req = 1'b0;
            step();
            chk({nm, ".end"}, 32'({bus.cpu_ack, bus.st_we, bus.st_wdata}), 32'd0);
        end else begin
            chk({nm, ".re"},   32'({bus.st_we, bus.st_re, bus.cpu_ack}), 32'd2);
            chk({nm, ".addr"}, 32'({bus.st_x, bus.st_y}), 32'({v.x, v.y}));
            step();
            bus.st_rdata = v.rdata;
            chk({nm, ".wait"}, 32'({bus.st_we, bus.st_re, bus.cpu_ack}), 32'd0);
            step();
            bus.st_rdata = ~v.rdata;
            chk({nm, ".ack"},   32'({bus.cpu_ack, bus.cpu_err}), 32'd2);
            chk({nm, ".rdata"}, 32'(bus.cpu_rdata), 32'(v.exp_rdata));
            bus.cpu_req = 1'b0;
            step();
            chk({nm, ".end"},  32'(bus.cpu_ack), 32'd0);
            chk({nm, ".hold"}, 32'(bus.cpu_rdata), 32'(v.exp_rdata));
        end
        step();
    endtask

    // Observes a sweep from its first write; pulses clear_start after write pulse_at
    // and returns early during write stop_at (use -1 to disable either).
    task automatic run_sweep(input int pulse_at, input int stop_at);
        int ex;
        int ey;
        bit prev_last;
        sw_writes  = 0;
        sw_bad     = 0;
        sw_done    = 1'b0;
        sw_done_ok = 1'b0;
        ex         = 0;
        ey         = 0;
        prev_last  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.clear_done) begin
                sw_done    = 1'b1;
                sw_done_ok = prev_last && !bus.st_we && !bus.clear_busy;
                break;
            end
            prev_last = 1'b0;
            if (bus.st_we) begin
                if (bus.st_x !== 5'(ex) || bus.st_y !== 5'(ey) || bus.st_wdata !== 4'd0 ||
                    bus.st_re || bus.cpu_ack || !bus.clear_busy) sw_bad++;
                sw_writes++;
                prev_last = (ex == COLS - 1) && (ey == ROWS - 1);
                if (ex == COLS - 1) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
                if (sw_writes == stop_at) break;
            end else begin
                sw_bad++;
            end
            bus.clear_start = (sw_writes == pulse_at);
            step();
        end
        bus.clear_start = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{we: 1'b1, x: 5'd3,  y: 5'd2,  wdata: 4'h5, rdata: 4'h0, exp_err: 1'b0, exp_rdata: 4'h0};
        vecs[1] = '{we: 1'b0, x: 5'd19, y: 5'd14, wdata: 4'h0, rdata: 4'h9, exp_err: 1'b0, exp_rdata: 4'h9};
        vecs[2] = '{we: 1'b0, x: 5'd20, y: 5'd0,  wdata: 4'h0, rdata: 4'h7, exp_err: 1'b1, exp_rdata: 4'h0};
        vecs[3] = '{we: 1'b1, x: 5'd0,  y: 5'd0,  wdata: 4'hF, rdata: 4'h0, exp_err: 1'b0, exp_rdata: 4'h0};
        vecs[4] = '{we: 1'b0, x: 5'd0,  y: 5'd0,  wdata: 4'h0, rdata: 4'h6, exp_err: 1'b0, exp_rdata: 4'h6};
        vecs[5] = '{we: 1'b1, x: 5'd19, y: 5'd15, wdata: 4'h3, rdata: 4'h0, exp_err: 1'b1, exp_rdata: 4'h0};
        vecs[6] = '{we: 1'b0, x: 5'd5,  y: 5'd7,  wdata: 4'h0, rdata: 4'hC, exp_err: 1'b0, exp_rdata: 4'hC};
        vecs[7] = '{we: 1'b1, x: 5'd19, y: 5'd14, wdata: 4'h1, rdata: 4'h0, exp_err: 1'b0, exp_rdata: 4'hC};
        vecs[8] = '{we: 1'b0, x: 5'd31, y: 5'd31, wdata: 4'h0, rdata: 4'hA, exp_err: 1'b1, exp_rdata: 4'h0};

        rst             = 1'b1;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_x       = 5'd0;
        bus.cpu_y       = 5'd0;
        bus.cpu_wdata   = 4'd0;
        bus.clear_start = 1'b0;
        bus.st_rdata    = 4'd0;
        step();
        step();
        chk("reset.pulses",  32'({bus.cpu_ack, bus.cpu_err, bus.clear_busy, bus.clear_done}), 32'd0);
        chk("reset.strobes", 32'({bus.st_we, bus.st_re}), 32'd0);
        chk("reset.bus",     32'({bus.st_x, bus.st_y, bus.st_wdata, bus.cpu_rdata}), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Request held through its ack is taken again as a new store.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_x     = 5'd4;
        bus.cpu_y     = 5'd4;
        bus.cpu_wdata = 4'h2;
        step();
        chk("b2b.first",  32'({bus.cpu_ack, bus.st_we}), 32'd3);
        step();
        chk("b2b.gap",    32'({bus.cpu_ack, bus.st_we}), 32'd0);
        step();
        chk("b2b.second", 32'({bus.cpu_ack, bus.st_we}), 32'd3);
        bus.cpu_req = 1'b0;
        step();
        chk("b2b.end",    32'({bus.cpu_ack, bus.st_we}), 32'd0);
        step();

        // Plain clear with no CPU traffic.
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        run_sweep(-1, -1);
        chk("clr.writes",  32'(sw_writes), 32'd300);
        chk("clr.order",   32'(sw_bad), 32'd0);
        chk("clr.done",    32'(sw_done), 32'd1);
        chk("clr.done_ok", 32'(sw_done_ok), 32'd1);
        step();
        chk("clr.after", 32'({bus.clear_done, bus.clear_busy, bus.st_we}), 32'd0);
        step();

        // Clear and store in the same idle cycle; a second clear_start mid-sweep is ignored.
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b1;
        bus.cpu_x       = 5'd7;
        bus.cpu_y       = 5'd3;
        bus.cpu_wdata   = 4'hA;
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        run_sweep(100, -1);
        chk("race.writes",  32'(sw_writes), 32'd300);
        chk("race.order",   32'(sw_bad), 32'd0);
        chk("race.done_ok", 32'({sw_done, sw_done_ok}), 32'd3);
        step();
        chk("race.store",  32'({bus.cpu_ack, bus.cpu_err, bus.st_we}), 32'd5);
        chk("race.addr",   32'({bus.st_x, bus.st_y, bus.st_wdata}), 32'({5'd7, 5'd3, 4'hA}));
        bus.cpu_req = 1'b0;
        step();
        chk("race.idle", 32'({bus.clear_busy, bus.st_we, bus.cpu_ack}), 32'd0);
        step();

        // Reset in the middle of a sweep abandons it.
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        run_sweep(-1, 150);
        chk("rst.reached", 32'(sw_writes), 32'd150);
        rst = 1'b1;
        #1;
        chk("rst.async", 32'({bus.st_we, bus.st_x, bus.st_y, bus.clear_busy, bus.cpu_ack}), 32'd0);
        step();
        chk("rst.nodone", 32'({bus.clear_done, bus.st_we}), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst.idle", 32'({bus.clear_done, bus.clear_busy, bus.st_we}), 32'd0);
        do_txn('{we: 1'b1, x: 5'd9, y: 5'd9, wdata: 4'h4, rdata: 4'h0, exp_err: 1'b0, exp_rdata: 4'h0},
               "rst.store");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/board_access_arbiter.md
BOARD_ACCESS_ARBITER -- requirements
Module: board_access_arbiter

Interface
REQ-001 Parameter COLS, default 20, number of board columns (x range 0..COLS-1).
REQ-002 Parameter ROWS, default 15, number of board rows (y range 0..ROWS-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU board-access request; held until cpu_ack.
REQ-006 cpu_we  input  1  1 = store, 0 = load; sampled with cpu_req.
REQ-007 cpu_x  input  5  column of request.
REQ-008 cpu_y  input  5  row of request.
REQ-009 cpu_wdata  input  4  cell state to store.
REQ-010 cpu_ack  output  1  one-cycle completion pulse.
REQ-011 cpu_err  output  1  valid with cpu_ack; 1 = address out of range.
REQ-012 cpu_rdata  output  4  load result, valid with cpu_ack.
REQ-013 clear_start  input  1  game-over/new-game pulse requesting a full board clear.
REQ-014 clear_busy  output  1  high while a clear is pending or sweeping.
REQ-015 clear_done  output  1  one-cycle pulse after last cell cleared.
REQ-016 st_we  output  1  storage write strobe.
REQ-017 st_re  output  1  storage read strobe.
REQ-018 st_x / st_y  output  5 each  storage cell address.
REQ-019 st_wdata  output  4  storage write data.
REQ-020 st_rdata  input  4  storage read data, valid exactly one cycle after st_re.

Function
REQ-021 The block SHALL be the sole master of the board cell store, sharing it between the CPU port and an internal clear engine.
REQ-022 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, ACK, CLEAR; all outputs registered.
REQ-023 In IDLE, priority SHALL be: clear pending > cpu_req.
REQ-024 IDLE with cpu_req=1, in-range, cpu_we=1 (cycle N): latch x,y,wdata; N+1 state WR, st_we=1 with latched address/data, cpu_ack=1, cpu_err=0; N+2 IDLE.
REQ-025 IDLE with cpu_req=1, in-range, cpu_we=0 (cycle N): N+1 RD_ISSUE, st_re=1; N+2 RD_WAIT captures st_rdata; N+3 ACK, cpu_ack=1, cpu_rdata=captured value; N+4 IDLE.
REQ-026 Out-of-range request (cpu_x>=COLS or cpu_y>=ROWS) SHALL go IDLE->ACK with cpu_ack=1, cpu_err=1, cpu_rdata=0, and no st_we/st_re.
REQ-027 cpu_req is not sampled in the cycle cpu_ack is high; a request still high the following cycle is a new request.
REQ-028 clear_start SHALL set a pending flag at any time except in CLEAR (ignored there); clear_busy=1 from the cycle after clear_start until clear_done.
REQ-029 A pending clear SHALL NOT abort an in-flight CPU transaction; it starts at the next IDLE.
REQ-030 CLEAR SHALL write 0 to every cell, one per cycle, row-major: (x=0,y=0),(1,0)...(COLS-1,0),(0,1)...(COLS-1,ROWS-1); ROWS*COLS consecutive st_we pulses (300 at defaults).
REQ-031 x counter wraps COLS-1->0 with y increment; after (COLS-1,ROWS-1) write, next cycle clear_done=1, clear_busy=0, state IDLE.
REQ-032 cpu_req during CLEAR SHALL stall (no ack) until the sweep completes, then be served.
REQ-033 st_we and st_re SHALL never be high in the same cycle; st_wdata=0, st_x=0, st_y=0 whenever both strobes are low.
REQ-034 cpu_ack, clear_done, cpu_err are single-cycle pulses; cpu_rdata holds its value until the next ack.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE, clear pending flag and counters, and drive all outputs to 0.
REQ-036 rst mid-transaction or mid-clear SHALL abandon it with no ack/done; partially cleared cells remain as written.

Verification
REQ-037 Store (x=3,y=2,wdata=5) -> one st_we at N+1 with st_x=3,st_y=2,st_wdata=5; cpu_ack=1, cpu_err=0 at N+1.
REQ-038 Load (x=19,y=14), st_rdata=9 at N+2 -> st_re at N+1, cpu_ack at N+3 with cpu_rdata=9.
REQ-039 Load (x=20,y=0) -> cpu_ack=1, cpu_err=1, cpu_rdata=0 at N+1; no st_re/st_we.
REQ-040 clear_start with no CPU traffic -> exactly 300 st_we pulses, first (0,0) last (19,14), st_wdata=0, clear_done one cycle after last write.
REQ-041 clear_start and cpu_req same IDLE cycle -> sweep first; CPU store completes after clear_done; second clear_start mid-sweep ignored (still 300 writes).
REQ-042 rst asserted at sweep write 150 -> outputs 0 immediately, no clear_done; after release, store request served normally.
